// File: rtl/adc_axis_pkg.sv
// Shared constants and beat layout for the ADC-to-AXI4-Stream framer.
package adc_axis_pkg;

   localparam int ADC_LENGTH_DEF = 12;
   localparam int OUT_W          = 16;
   localparam int GAIN_W         = 32;
   localparam int GAIN_FRAC      = 16;
   localparam int DROP_W         = 16;
   localparam int BEAT_W         = 2 * OUT_W + 1;

   localparam logic signed [OUT_W-1:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [OUT_W-1:0] SAT_MIN = 16'sh8000;

   // One FIFO entry: frame-end marker above the packed {ch2, ch1} word.
   typedef struct packed {
      logic                 last;
      logic [2*OUT_W-1:0]   data;
   } beat_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible whenever empty is low.
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // Extra pointer bit separates the full and empty cases when the addresses match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/adc_axis_framer.sv
// Offset/gain correction of dual-channel ADC samples, packed into framed AXI4-Stream beats
// through a small FIFO with overflow accounting.
module adc_axis_framer
   import adc_axis_pkg::*;
#(
   parameter int ADC_LENGTH = ADC_LENGTH_DEF,
   parameter int FIFO_DEPTH = 16,
   parameter int FRAME_LEN  = 256
) (
   input  logic                     CLK100MHz,
   input  logic                     ARESETN,
   input  logic                     en,
   input  logic                     clear,
   input  logic                     data_rdy_i,
   input  logic [ADC_LENGTH-1:0]    adc1_i,
   input  logic [ADC_LENGTH-1:0]    adc2_i,
   input  logic [ADC_LENGTH-1:0]    offset,
   input  logic signed [GAIN_W-1:0] gain,
   output logic [2*OUT_W-1:0]       m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_count
);

   localparam int DIFF_W = ADC_LENGTH + 1;
   localparam int PROD_W = DIFF_W + GAIN_W;
   localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [CNT_W-1:0]         FRAME_LAST = CNT_W'(FRAME_LEN - 1);
   localparam logic signed [PROD_W-1:0] RND_HALF   =
      {{(PROD_W-GAIN_FRAC){1'b0}}, 1'b1, {(GAIN_FRAC-1){1'b0}}};
   localparam logic signed [PROD_W-1:0] SAT_HI = {{(PROD_W-OUT_W){1'b0}}, SAT_MAX};
   localparam logic signed [PROD_W-1:0] SAT_LO = {{(PROD_W-OUT_W){1'b1}}, SAT_MIN};

   function automatic logic signed [PROD_W-1:0] round_q(input logic signed [PROD_W-1:0] p);
      return (p + RND_HALF) >>> GAIN_FRAC;
   endfunction

   function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [PROD_W-1:0] v);
      if (v > SAT_HI)      return SAT_MAX;
      else if (v < SAT_LO) return SAT_MIN;
      else                 return v[OUT_W-1:0];
   endfunction

   logic                     rdy_prev;
   logic                     edge_p0;
   logic                     vld_p1, vld_p2, vld_p3, vld_p4;
   logic [ADC_LENGTH-1:0]    raw1_p1, raw2_p1;
   logic signed [DIFF_W-1:0] diff1_p2, diff2_p2;
   logic signed [PROD_W-1:0] diff1_x, diff2_x, gain_x;
   logic signed [PROD_W-1:0] prod1_p3, prod2_p3;
   logic signed [OUT_W-1:0]  res1_p4, res2_p4;
   logic [CNT_W-1:0]         frame_cnt;
   logic                     fifo_full, fifo_empty, fifo_wr, fifo_rd, drop;
   beat_t                    wr_beat, head;

   // Stage 0: one event per rising edge of data-ready, gated by en on that cycle only.
   assign edge_p0 = data_rdy_i && !rdy_prev && en;

   assign diff1_x = {{GAIN_W{diff1_p2[DIFF_W-1]}}, diff1_p2};
   assign diff2_x = {{GAIN_W{diff2_p2[DIFF_W-1]}}, diff2_p2};
   assign gain_x  = {{DIFF_W{gain[GAIN_W-1]}}, gain};

   always_ff @(posedge CLK100MHz) begin
      // Stage 1: capture raw pair
      if (edge_p0) begin
         raw1_p1 <= adc1_i;
         raw2_p1 <= adc2_i;
      end
      // Stage 2: remove offset
      if (vld_p1) begin
         diff1_p2 <= $signed({1'b0, raw1_p1}) - $signed({1'b0, offset});
         diff2_p2 <= $signed({1'b0, raw2_p1}) - $signed({1'b0, offset});
      end
      // Stage 3: apply Q16.16 gain
      if (vld_p2) begin
         prod1_p3 <= diff1_x * gain_x;
         prod2_p3 <= diff2_x * gain_x;
      end
      // Stage 4: round half-up and clamp to the output range
      if (vld_p3) begin
         res1_p4 <= sat_out(round_q(prod1_p3));
         res2_p4 <= sat_out(round_q(prod2_p3));
      end
   end

   always_ff @(posedge CLK100MHz or negedge ARESETN) begin
      if (!ARESETN) begin
         rdy_prev <= 1'b0;
         vld_p1   <= 1'b0;
         vld_p2   <= 1'b0;
         vld_p3   <= 1'b0;
         vld_p4   <= 1'b0;
      end else begin
         rdy_prev <= data_rdy_i;
         vld_p1   <= edge_p0;
         vld_p2   <= vld_p1;
         vld_p3   <= vld_p2;
         vld_p4   <= vld_p3;
      end
   end

   // Full is judged before any same-cycle read, so a write into a full FIFO is always lost.
   assign fifo_wr      = vld_p4 && !fifo_full;
   assign drop         = vld_p4 && fifo_full;
   assign wr_beat.last = (frame_cnt == FRAME_LAST);
   assign wr_beat.data = {res2_p4, res1_p4};

   always_ff @(posedge CLK100MHz or negedge ARESETN) begin
      if (!ARESETN) begin
         frame_cnt  <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear) begin
         frame_cnt  <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (fifo_wr) frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + CNT_W'(1);
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != {DROP_W{1'b1}}) drop_count <= drop_count + DROP_W'(1);
         end
      end
   end

   sync_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (CLK100MHz),
      .rst_n   (ARESETN),
      .wr_en   (fifo_wr),
      .wr_data (wr_beat),
      .rd_en   (fifo_rd),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Head of an FWFT FIFO is stable until popped, which keeps the beat steady under back-pressure.
   assign m_axis_tvalid = !fifo_empty;
   assign fifo_rd       = m_axis_tvalid && m_axis_tready;
   assign m_axis_tdata  = fifo_empty ? '0 : head.data;
   assign m_axis_tlast  = !fifo_empty && head.last;

endmodule
